// File: rtl/icb_apb_arb.sv
// Round-robin arbiter sharing one ICB target (normally the ICB-to-APB bridge) between NREQ requesters.
// Build option: define ICB_APB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module icb_apb_arb #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        r_cmd_valid,
    output logic [NREQ-1:0]        r_cmd_ready,
    input  logic [NREQ-1:0]        r_cmd_read,
    input  logic [NREQ*AW-1:0]     r_cmd_addr,
    input  logic [NREQ*DW-1:0]     r_cmd_wdata,
    input  logic [NREQ*DW/8-1:0]   r_cmd_wmask,
    input  logic [NREQ*2-1:0]      r_cmd_size,
    output logic [NREQ-1:0]        r_rsp_valid,
    input  logic [NREQ-1:0]        r_rsp_ready,
    output logic [NREQ-1:0]        r_rsp_err,
    output logic [NREQ*DW-1:0]     r_rsp_rdata,
    output logic                   o_cmd_valid,
    input  logic                   o_cmd_ready,
    output logic                   o_cmd_read,
    output logic [AW-1:0]          o_cmd_addr,
    output logic [DW-1:0]          o_cmd_wdata,
    output logic [DW/8-1:0]        o_cmd_wmask,
    output logic [1:0]             o_cmd_size,
    input  logic                   o_rsp_valid,
    output logic                   o_rsp_ready,
    input  logic                   o_rsp_err,
    input  logic [DW-1:0]          o_rsp_rdata,
    output logic                   busy,
    output logic [1:0]             grant_idx
);

    localparam int         MW    = DW / 8;
    localparam logic [2:0] NREQ3 = 3'(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      ptr_q;
    logic [1:0]      grant_q;

    logic [NREQ-1:0] rot;
    logic [1:0]      off;
    logic [2:0]      sum;
    logic [1:0]      winner_d;
    logic            g_valid;
    logic            g_rsp_ready;

    // Rotate the request vector so bit 0 is the requester at ptr; the lowest set bit is the winner.
    always_comb begin
        rot = NREQ'({r_cmd_valid, r_cmd_valid} >> ptr_q);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= NREQ3) sum = sum - NREQ3;
        winner_d = sum[1:0];
    end

`ifndef ICB_APB_ARB_FIXED_PRIO_EN
    logic [2:0] ptr_inc;
    logic [1:0] ptr_d;
    always_comb begin
        ptr_inc = {1'b0, grant_q} + 3'd1;
        ptr_d   = (ptr_inc >= NREQ3) ? 2'd0 : ptr_inc[1:0];
    end
`endif

    always_comb begin
        g_valid     = 1'b0;
        g_rsp_ready = 1'b0;
        o_cmd_read  = 1'b0;
        o_cmd_addr  = '0;
        o_cmd_wdata = '0;
        o_cmd_wmask = '0;
        o_cmd_size  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q == 2'(k)) begin
                g_valid     = r_cmd_valid[k];
                g_rsp_ready = r_rsp_ready[k];
                o_cmd_read  = r_cmd_read[k];
                o_cmd_addr  = r_cmd_addr[k*AW +: AW];
                o_cmd_wdata = r_cmd_wdata[k*DW +: DW];
                o_cmd_wmask = r_cmd_wmask[k*MW +: MW];
                o_cmd_size  = r_cmd_size[k*2 +: 2];
            end
        end
    end

    // Handshakes are valid/ready: a beat transfers on a rising edge where both are high.
    // Each channel is only opened in its own phase, so an early target response waits.
    always_comb begin
        r_cmd_ready = '0;
        r_rsp_valid = '0;
        r_rsp_err   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q == 2'(k)) begin
                r_cmd_ready[k] = (state_q == CMD) & o_cmd_ready;
                r_rsp_valid[k] = (state_q == RSP) & o_rsp_valid;
                r_rsp_err[k]   = (state_q == RSP) & o_rsp_err;
            end
        end
    end

    assign o_cmd_valid = (state_q == CMD) & g_valid;
    assign o_rsp_ready = (state_q == RSP) & g_rsp_ready;
    assign r_rsp_rdata = {NREQ{o_rsp_rdata}};
    assign busy        = (state_q != IDLE);
    assign grant_idx   = grant_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|r_cmd_valid) begin
                        grant_q <= winner_d;
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    // A withdrawn request abandons the grant without advancing the pointer.
                    if (!g_valid)         state_q <= IDLE;
                    else if (o_cmd_ready) state_q <= RSP;
                end
                RSP: begin
                    if (o_rsp_valid && g_rsp_ready) begin
                        state_q <= IDLE;
`ifdef ICB_APB_ARB_FIXED_PRIO_EN
                        ptr_q   <= '0;
`else
                        ptr_q   <= ptr_d;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icb_apb_arb.sv
// Directed table-driven bench for icb_apb_arb (NREQ=2, AW=32, DW=64); honours ICB_APB_ARB_FIXED_PRIO_EN.
module tb_icb_apb_arb;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 64;

    localparam logic [31:0] ADDR0 = 32'h1000_0040;
    localparam logic [31:0] ADDR1 = 32'h2000_0080;
    localparam logic [63:0] WD0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WD1   = 64'hCAFE_F00D_5555_AAAA;
    localparam logic [63:0] RDATA = 64'hDEAD_BEEF_0000_0001;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       r_cmd_valid;
    logic [NREQ-1:0]       r_cmd_ready;
    logic [NREQ-1:0]       r_cmd_read;
    logic [NREQ*AW-1:0]    r_cmd_addr;
    logic [NREQ*DW-1:0]    r_cmd_wdata;
    logic [NREQ*DW/8-1:0]  r_cmd_wmask;
    logic [NREQ*2-1:0]     r_cmd_size;
    logic [NREQ-1:0]       r_rsp_valid;
    logic [NREQ-1:0]       r_rsp_ready;
    logic [NREQ-1:0]       r_rsp_err;
    logic [NREQ*DW-1:0]    r_rsp_rdata;
    logic                  o_cmd_valid;
    logic                  o_cmd_ready;
    logic                  o_cmd_read;
    logic [AW-1:0]         o_cmd_addr;
    logic [DW-1:0]         o_cmd_wdata;
    logic [DW/8-1:0]       o_cmd_wmask;
    logic [1:0]            o_cmd_size;
    logic                  o_rsp_valid;
    logic                  o_rsp_ready;
    logic                  o_rsp_err;
    logic [DW-1:0]         o_rsp_rdata;
    logic                  busy;
    logic [1:0]            grant_idx;

    icb_apb_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .r_cmd_valid (r_cmd_valid),
        .r_cmd_ready (r_cmd_ready),
        .r_cmd_read  (r_cmd_read),
        .r_cmd_addr  (r_cmd_addr),
        .r_cmd_wdata (r_cmd_wdata),
        .r_cmd_wmask (r_cmd_wmask),
        .r_cmd_size  (r_cmd_size),
        .r_rsp_valid (r_rsp_valid),
        .r_rsp_ready (r_rsp_ready),
        .r_rsp_err   (r_rsp_err),
        .r_rsp_rdata (r_rsp_rdata),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .o_cmd_read  (o_cmd_read),
        .o_cmd_addr  (o_cmd_addr),
        .o_cmd_wdata (o_cmd_wdata),
        .o_cmd_wmask (o_cmd_wmask),
        .o_cmd_size  (o_cmd_size),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_ready (o_rsp_ready),
        .o_rsp_err   (o_rsp_err),
        .o_rsp_rdata (o_rsp_rdata),
        .busy        (busy),
        .grant_idx   (grant_idx)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic       rst_n;
        logic [1:0] cv;
        logic       ocr;
        logic       orv;
        logic       err;
        logic [1:0] rr;
        logic       e_ocv;
        logic [1:0] e_rcr;
        logic [1:0] e_rrv;
        logic       e_orr;
        logic       e_busy;
        logic [1:0] e_g;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;
    logic [1:0] gc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input logic [1:0] g);
        return (g == 2'd0) ? 2'b01 : 2'b10;
    endfunction

    function automatic void add(input string nm, input logic rs, input logic [1:0] cv,
                                input logic ocr, input logic orv, input logic err,
                                input logic [1:0] rr, input logic eocv, input logic [1:0] ercr,
                                input logic [1:0] errv, input logic eorr, input logic ebusy,
                                input logic [1:0] eg);
        vec_t v;
        v.name = nm; v.rst_n = rs; v.cv = cv; v.ocr = ocr; v.orv = orv; v.err = err; v.rr = rr;
        v.e_ocv = eocv; v.e_rcr = ercr; v.e_rrv = errv; v.e_orr = eorr; v.e_busy = ebusy; v.e_g = eg;
        tbl.push_back(v);
    endfunction

    // Driver: apply one row after the falling edge, compare 1 ns later.
    task automatic apply_row(input vec_t v);
        logic [1:0] e_err;
        @(negedge clk);
        rst         = v.rst_n;
        r_cmd_valid = v.cv;
        o_cmd_ready = v.ocr;
        o_rsp_valid = v.orv;
        o_rsp_err   = v.err;
        r_rsp_ready = v.rr;
        #1;
        e_err = v.e_rrv & {2{v.err}};
        chk({v.name, ".o_cmd_valid"}, 64'(o_cmd_valid), 64'(v.e_ocv));
        chk({v.name, ".r_cmd_ready"}, 64'(r_cmd_ready), 64'(v.e_rcr));
        chk({v.name, ".r_rsp_valid"}, 64'(r_rsp_valid), 64'(v.e_rrv));
        chk({v.name, ".r_rsp_err"},   64'(r_rsp_err),   64'(e_err));
        chk({v.name, ".o_rsp_ready"}, 64'(o_rsp_ready), 64'(v.e_orr));
        chk({v.name, ".busy"},        64'(busy),        64'(v.e_busy));
        chk({v.name, ".grant_idx"},   64'(grant_idx),   64'(v.e_g));
        if (v.e_ocv)
            chk({v.name, ".o_cmd_addr"}, 64'(o_cmd_addr), 64'((v.e_g == 2'd0) ? ADDR0 : ADDR1));
        if (v.e_rrv[0]) chk({v.name, ".rdata0"}, r_rsp_rdata[0 +: 64],  RDATA);
        if (v.e_rrv[1]) chk({v.name, ".rdata1"}, r_rsp_rdata[64 +: 64], RDATA);
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
`ifdef ICB_APB_ARB_FIXED_PRIO_EN
        gc = 2'd0;
`else
        gc = 2'd1;
`endif
        rst         = 1'b0;
        r_cmd_valid = '0;
        r_cmd_read  = 2'b01;
        r_cmd_addr  = {ADDR1, ADDR0};
        r_cmd_wdata = {WD1, WD0};
        r_cmd_wmask = {8'h0F, 8'hFF};
        r_cmd_size  = {2'b11, 2'b10};
        r_rsp_ready = '0;
        o_cmd_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_rdata = RDATA;
        repeat (2) @(negedge clk);

        //   name  rst cv     ocr orv err rr   | ocv rcr    rrv    orr busy g
        add("rst", 0, 2'b11, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        // single read by r0, bridge-style target (ready one cycle late)
        add("rd",  1, 2'b01, 0, 0, 0, 2'b01,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("rd",  1, 2'b01, 0, 0, 0, 2'b01,   1, 2'b00, 2'b00, 0, 1, 2'd0);
        add("rd",  1, 2'b01, 1, 0, 0, 2'b01,   1, 2'b01, 2'b00, 0, 1, 2'd0);
        add("rd",  1, 2'b00, 0, 1, 0, 2'b01,   0, 2'b00, 2'b01, 1, 1, 2'd0);
        add("rd",  1, 2'b00, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        // contention from reset: 4 transfers, both requesters always valid
        add("ct",  0, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   1, 2'b01, 2'b00, 0, 1, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b01, 1, 1, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   1, oh(gc), 2'b00, 0, 1, gc);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, oh(gc), 1, 1, gc);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b00, 0, 0, gc);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   1, 2'b01, 2'b00, 0, 1, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b01, 1, 1, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   1, oh(gc), 2'b00, 0, 1, gc);
        add("ct",  1, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, oh(gc), 1, 1, gc);
        add("ct",  1, 2'b00, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, gc);
        // r1 holds response ready low for 5 cycles while r0 is waiting
        add("bp",  1, 2'b10, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, gc);
        add("bp",  1, 2'b10, 1, 0, 0, 2'b00,   1, 2'b10, 2'b00, 0, 1, 2'd1);
        for (int i = 0; i < 5; i++)
            add("bp", 1, 2'b11, 1, 1, 0, 2'b00, 0, 2'b00, 2'b10, 0, 1, 2'd1);
        add("bp",  1, 2'b01, 1, 1, 1, 2'b10,   0, 2'b00, 2'b10, 1, 1, 2'd1);
        add("bp",  1, 2'b00, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd1);
        // target response raised early, during IDLE and CMD
        add("er",  1, 2'b01, 0, 1, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd1);
        add("er",  1, 2'b01, 0, 1, 0, 2'b01,   1, 2'b00, 2'b00, 0, 1, 2'd0);
        add("er",  1, 2'b01, 1, 1, 0, 2'b01,   1, 2'b01, 2'b00, 0, 1, 2'd0);
        add("er",  1, 2'b00, 0, 1, 0, 2'b01,   0, 2'b00, 2'b01, 1, 1, 2'd0);
        add("er",  1, 2'b00, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        // r1 granted then withdraws; r0 pending gets the next grant
        add("wd",  1, 2'b10, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("wd",  1, 2'b01, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 1, 2'd1);
        add("wd",  1, 2'b01, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd1);
        add("wd",  1, 2'b01, 1, 0, 0, 2'b00,   1, 2'b01, 2'b00, 0, 1, 2'd0);
        add("wd",  1, 2'b00, 0, 1, 0, 2'b01,   0, 2'b00, 2'b01, 1, 1, 2'd0);
        add("wd",  1, 2'b00, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        // reset asserted while r1 sits in RSP; afterwards arbitration restarts at 0
        add("rs",  1, 2'b10, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("rs",  1, 2'b10, 1, 0, 0, 2'b00,   1, 2'b10, 2'b00, 0, 1, 2'd1);
        add("rs",  1, 2'b00, 0, 1, 0, 2'b00,   0, 2'b00, 2'b10, 0, 1, 2'd1);
        add("rs",  0, 2'b11, 1, 1, 0, 2'b11,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("rs",  1, 2'b11, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);
        add("rs",  1, 2'b11, 0, 0, 0, 2'b00,   1, 2'b00, 2'b00, 0, 1, 2'd0);
        add("rs",  1, 2'b11, 1, 0, 0, 2'b00,   1, 2'b01, 2'b00, 0, 1, 2'd0);
        add("rs",  1, 2'b00, 0, 1, 1, 2'b11,   0, 2'b00, 2'b01, 1, 1, 2'd0);
        add("rs",  1, 2'b00, 0, 0, 0, 2'b00,   0, 2'b00, 2'b00, 0, 0, 2'd0);

        foreach (tbl[i]) apply_row(tbl[i]);

        // Hand sequence: r1 write through a bridge-like target, checking field muxing and latency.
        @(negedge clk);
        r_cmd_valid = 2'b10;
        #1;
        chk("wr.idle_ocv", 64'(o_cmd_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("wr.latency_ocv", 64'(o_cmd_valid), 64'd1);
        chk("wr.grant", 64'(grant_idx), 64'd1);
        @(negedge clk);
        o_cmd_ready = 1'b1;
        #1;
        chk("wr.r_cmd_ready", 64'(r_cmd_ready), 64'(2'b10));
        chk("wr.read",  64'(o_cmd_read),  64'd0);
        chk("wr.addr",  64'(o_cmd_addr),  64'(ADDR1));
        chk("wr.wdata", o_cmd_wdata,      WD1);
        chk("wr.wmask", 64'(o_cmd_wmask), 64'(8'h0F));
        chk("wr.size",  64'(o_cmd_size),  64'(2'b11));
        @(negedge clk);
        o_cmd_ready = 1'b0;
        r_cmd_valid = 2'b00;
        o_rsp_valid = 1'b1;
        r_rsp_ready = 2'b10;
        #1;
        chk("wr.r_rsp_valid", 64'(r_rsp_valid), 64'(2'b10));
        chk("wr.o_rsp_ready", 64'(o_rsp_ready), 64'd1);
        @(negedge clk);
        o_rsp_valid = 1'b0;
        r_rsp_ready = 2'b00;
        #1;
        n = 0;
        while (busy && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wr.busy_drop", 64'(busy), 64'd0);
        chk("wr.grant_hold", 64'(grant_idx), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
